// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants for the VGA timing generator: the 640x480@60 Hz line and
// frame geometry, the default picture window, the coordinate width and the
// sync polarity encodings. Also a small range helper used by the decoders.
// No ports (package).
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    localparam int VGA_PIC_X = 256;
    localparam int VGA_PIC_Y = 176;
    localparam int VGA_PIC_W = 128;
    localparam int VGA_PIC_H = 128;

    // True when lo <= val < lo+len.
    function automatic logic in_span(input int val, input int lo, input int len);
        return (val >= lo) && (val < lo + len);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// Up-counter 0..MODULUS-1 for one raster axis. Advances when en is high and
// wraps to 0 after MODULUS-1. The next-state value is exported so the top
// level can decode one cycle ahead.
// Ports:
//   vga_clk   in   pixel clock
//   rst_n     in   asynchronous active-low reset (count -> 0)
//   en        in   count enable
//   cnt       out  current count
//   cnt_next  out  value cnt takes on the next edge
//   wrap      out  high in the cycle the count goes MODULUS-1 -> 0
// ---------------------------------------------------------------------------
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int MODULUS = VGA_H_TOTAL
) (
    input  logic               vga_clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [COORD_W-1:0] cnt,
    output logic [COORD_W-1:0] cnt_next,
    output logic               wrap
);

    localparam logic [COORD_W-1:0] LAST = COORD_W'(MODULUS - 1);

    assign wrap = en && (cnt == LAST);

    always_comb begin
        cnt_next = cnt;
        if (wrap) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = cnt + 1'b1;
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock. All outputs
// are registered; everything except data_read_active is decoded from the
// current counters (one-cycle lag, mutually aligned). data_read_active is
// decoded from the next-state counters so it leads output_display by one
// cycle, covering one cycle of synchronous sprite-ROM latency.
// Optional feature macro: VGA_FRAME_CNT_EN adds an 8-bit frame counter.
// Ports:
//   vga_clk           in   pixel clock
//   rst_n             in   asynchronous active-low reset
//   hsync, vsync      out  sync outputs, asserted level SYNC_POL
//   output_display    out  pixel is inside the visible area
//   h_addr, v_addr    out  visible coordinates, 0 outside the active area
//   data_read_active  out  one-cycle-early read enable
//   picture_active    out  pixel is inside the (clipped) picture window
//   frame_start       out  pulse on the (0,0) pixel of every frame
//   frame_cnt         out  frame counter (VGA_FRAME_CNT_EN only)
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = SYNC_ACTIVE_LOW,
    parameter int PIC_X    = VGA_PIC_X,
    parameter int PIC_Y    = VGA_PIC_Y,
    parameter int PIC_W    = VGA_PIC_W,
    parameter int PIC_H    = VGA_PIC_H
) (
    input  logic               vga_clk,
    input  logic               rst_n,
    output logic               hsync,
    output logic               vsync,
    output logic               output_display,
    output logic [COORD_W-1:0] h_addr,
    output logic [COORD_W-1:0] v_addr,
    output logic               data_read_active,
    output logic               picture_active,
    output logic               frame_start
`ifdef VGA_FRAME_CNT_EN
   ,output logic [7:0]         frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [COORD_W-1:0] h_cnt, h_next;
    logic [COORD_W-1:0] v_cnt, v_next;
    logic               h_wrap, v_wrap;

    vga_axis_counter #(.MODULUS(H_TOTAL)) u_h_cnt (
        .vga_clk  (vga_clk),
        .rst_n    (rst_n),
        .en       (1'b1),
        .cnt      (h_cnt),
        .cnt_next (h_next),
        .wrap     (h_wrap)
    );

    vga_axis_counter #(.MODULUS(V_TOTAL)) u_v_cnt (
        .vga_clk  (vga_clk),
        .rst_n    (rst_n),
        .en       (h_wrap),
        .cnt      (v_cnt),
        .cnt_next (v_next),
        .wrap     (v_wrap)
    );

    logic h_act, v_act, act, h_sync_on, v_sync_on, pic_on, act_next;

    always_comb begin
        h_act     = in_span(int'(h_cnt), 0, H_ACTIVE);
        v_act     = in_span(int'(v_cnt), 0, V_ACTIVE);
        act       = h_act && v_act;
        h_sync_on = in_span(int'(h_cnt), H_ACTIVE + H_FP, H_SYNC);
        v_sync_on = in_span(int'(v_cnt), V_ACTIVE + V_FP, V_SYNC);
        // Window is ANDed with the active area so an oversized window clips.
        pic_on    = act && in_span(int'(h_cnt), PIC_X, PIC_W)
                        && in_span(int'(v_cnt), PIC_Y, PIC_H);
        act_next  = in_span(int'(h_next), 0, H_ACTIVE)
                 && in_span(int'(v_next), 0, V_ACTIVE);
    end

    // The counters sit at (0,0) exactly after reset and after a frame wrap,
    // since the horizontal counter never stalls; this flag marks that cycle.
    logic at_origin;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync            <= ~SYNC_POL;
            vsync            <= ~SYNC_POL;
            output_display   <= 1'b0;
            h_addr           <= '0;
            v_addr           <= '0;
            data_read_active <= 1'b0;
            picture_active   <= 1'b0;
            frame_start      <= 1'b0;
            at_origin        <= 1'b1;
        end else begin
            hsync            <= h_sync_on ? SYNC_POL : ~SYNC_POL;
            vsync            <= v_sync_on ? SYNC_POL : ~SYNC_POL;
            output_display   <= act;
            h_addr           <= act ? h_cnt : '0;
            v_addr           <= act ? v_cnt : '0;
            data_read_active <= act_next;
            picture_active   <= pic_on;
            frame_start      <= at_origin;
            at_origin        <= v_wrap;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Steps on the same edge that raises frame_start.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (at_origin) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Bench for vga_timing_gen using a scaled-down raster (12 x 10 clocks per
// frame) so that multi-frame and 257-frame scenarios stay short. Expected
// outputs come from an arithmetic model of raster position versus clock
// count since reset release, queued per edge and compared after the edge.
// Define VGA_FRAME_CNT_EN to also exercise the frame counter.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 1, HS = 2, HB = 1, HT = HA + HF + HS + HB;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int PX = 3, PY = 2, PW = 4, PH = 8;   // vertically clipped window

    logic       vga_clk;
    logic       rst_n;
    logic       hsync, vsync, output_display, data_read_active, picture_active, frame_start;
    logic [9:0] h_addr, v_addr;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0),
        .PIC_X(PX), .PIC_Y(PY), .PIC_W(PW), .PIC_H(PH)
    ) dut (
        .vga_clk          (vga_clk),
        .rst_n            (rst_n),
        .hsync            (hsync),
        .vsync            (vsync),
        .output_display   (output_display),
        .h_addr           (h_addr),
        .v_addr           (v_addr),
        .data_read_active (data_read_active),
        .picture_active   (picture_active),
        .frame_start      (frame_start)
`ifdef VGA_FRAME_CNT_EN
       ,.frame_cnt        (frame_cnt)
`endif
    );

    initial vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    typedef logic [25:0] vec_t;
    localparam vec_t RESET_VEC = {1'b1, 1'b1, 24'b0};

    vec_t obs;
    assign obs = {hsync, vsync, output_display, data_read_active, picture_active,
                  frame_start, h_addr, v_addr};

    vec_t sb_q[$];
    int   edges;        // rising edges since reset release
    int   vectors;
    int   miscompares;

    function automatic logic act_at(input int p);
        int h, v;
        h = p % HT;
        v = (p / HT) % VT;
        return (h < HA) && (v < VA);
    endfunction

    // Outputs expected after edge e (e >= 1) following reset release.
    function automatic vec_t model(input int e);
        int p, h, v;
        logic act, hs, vs, pic, fs, dra;
        p   = e - 1;
        h   = p % HT;
        v   = (p / HT) % VT;
        act = (h < HA) && (v < VA);
        hs  = (h >= HA + HF && h < HA + HF + HS) ? 1'b0 : 1'b1;
        vs  = (v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1;
        pic = act && h >= PX && h < PX + PW && v >= PY && v < PY + PH;
        fs  = (p % FT) == 0;
        dra = act_at(e);
        return {hs, vs, act, dra, pic, fs, 10'(act ? h : 0), 10'(act ? v : 0)};
    endfunction

    task automatic advance();
        sb_q.push_back(model(edges + 1));
        @(posedge vga_clk);
        edges++;
        #1;
    endtask

    task automatic test_reset();
        vec_t exp;
        rst_n = 1'b0;
        edges = 0;
        repeat (5) begin
            @(posedge vga_clk);
            #1;
            vectors++;
            if (obs !== RESET_VEC) begin
                miscompares++;
                $display("FAIL reset_hold actual=%h required=%h", obs, RESET_VEC);
            end
`ifdef VGA_FRAME_CNT_EN
            vectors++;
            if (frame_cnt !== 8'd0) begin
                miscompares++;
                $display("FAIL reset_frame_cnt actual=%0d required=0", frame_cnt);
            end
`endif
        end
        @(negedge vga_clk);
        rst_n = 1'b1;
        advance();
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_release_sb edge=%0d actual=%h required=%h", edges, obs, exp);
        end
        vectors++;
        if (output_display !== 1'b1 || frame_start !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_edge actual disp=%b fs=%b required disp=1 fs=1",
                     output_display, frame_start);
        end
    endtask

    task automatic test_line_timing();
        vec_t exp;
        int disp_cnt, hs_cnt, hs_first, dra_fall, disp_fall;
        logic prev_dra, prev_disp, dra_end, disp_end;
        disp_cnt = 0; hs_cnt = 0; hs_first = -1; dra_fall = -1; disp_fall = -1;
        dra_end = 1'b0; disp_end = 1'b1;
        while (edges < HT) begin
            advance();
            exp = sb_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL line_sb edge=%0d actual=%h required=%h", edges, obs, exp);
            end
        end
        prev_dra = data_read_active;
        prev_disp = output_display;
        for (int off = 0; off < HT; off++) begin
            advance();
            exp = sb_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL line_sb edge=%0d actual=%h required=%h", edges, obs, exp);
            end
            if (output_display) disp_cnt++;
            if (!hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = off;
            end
            if (prev_dra && !data_read_active && dra_fall < 0) dra_fall = off;
            if (prev_disp && !output_display && disp_fall < 0) disp_fall = off;
            if (off == HT - 1) begin
                dra_end  = data_read_active;
                disp_end = output_display;
            end
            prev_dra  = data_read_active;
            prev_disp = output_display;
        end
        vectors++;
        if (disp_cnt != HA) begin
            miscompares++;
            $display("FAIL line_display_len actual=%0d required=%0d", disp_cnt, HA);
        end
        vectors++;
        if (hs_cnt != HS || hs_first != HA + HF) begin
            miscompares++;
            $display("FAIL line_hsync actual len=%0d start=%0d required len=%0d start=%0d",
                     hs_cnt, hs_first, HS, HA + HF);
        end
        vectors++;
        if (dra_fall != HA - 1 || disp_fall != HA) begin
            miscompares++;
            $display("FAIL line_dra_fall_lead actual dra=%0d disp=%0d required dra=%0d disp=%0d",
                     dra_fall, disp_fall, HA - 1, HA);
        end
        vectors++;
        if (dra_end !== 1'b1 || disp_end !== 1'b0) begin
            miscompares++;
            $display("FAIL line_dra_rise_lead actual dra=%b disp=%b required dra=1 disp=0",
                     dra_end, disp_end);
        end
        advance();
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp || h_addr !== 10'd0 || output_display !== 1'b1) begin
            miscompares++;
            $display("FAIL line_period actual=%h required=%h", obs, exp);
        end
    endtask

    task automatic test_frame_timing();
        vec_t exp;
        int vs_low, vs_first, fs_n, fs_first, fs_second, blank_nz;
        logic prev_vs;
        vs_low = 0; vs_first = -1; fs_n = 0; fs_first = -1; fs_second = -1; blank_nz = 0;
        while ((edges % FT) != 0) begin
            advance();
            exp = sb_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL frame_sb edge=%0d actual=%h required=%h", edges, obs, exp);
            end
        end
        prev_vs = vsync;
        for (int i = 0; i < 2 * FT; i++) begin
            advance();
            exp = sb_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL frame_sb edge=%0d actual=%h required=%h", edges, obs, exp);
            end
            if (!vsync) vs_low++;
            if (prev_vs && !vsync && vs_first < 0) vs_first = i;
            if (frame_start) begin
                if (fs_n == 0) fs_first = i;
                else if (fs_n == 1) fs_second = i;
                fs_n++;
            end
            if (!output_display && v_addr != 10'd0) blank_nz++;
            prev_vs = vsync;
        end
        vectors++;
        if (vs_low != 2 * VS * HT || vs_first != (VA + VF) * HT) begin
            miscompares++;
            $display("FAIL frame_vsync actual low=%0d start=%0d required low=%0d start=%0d",
                     vs_low, vs_first, 2 * VS * HT, (VA + VF) * HT);
        end
        vectors++;
        if (fs_n != 2 || fs_second - fs_first != FT) begin
            miscompares++;
            $display("FAIL frame_start_period actual n=%0d gap=%0d required n=2 gap=%0d",
                     fs_n, fs_second - fs_first, FT);
        end
        vectors++;
        if (blank_nz != 0) begin
            miscompares++;
            $display("FAIL frame_blank_vaddr actual=%0d required=0", blank_nz);
        end
        advance();
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp || frame_start !== 1'b1 || v_addr !== 10'd0) begin
            miscompares++;
            $display("FAIL frame_wrap actual=%h required=%h", obs, exp);
        end
    endtask

    task automatic test_picture();
        vec_t exp;
        int pic_cnt, rise_h, rise_v, falls, bad_falls, last_row;
        logic prev_pic;
        logic [9:0] prev_h;
        pic_cnt = 0; rise_h = -1; rise_v = -1; falls = 0; bad_falls = 0; last_row = -1;
        while ((edges % FT) != 0) begin
            advance();
            exp = sb_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL pic_sb edge=%0d actual=%h required=%h", edges, obs, exp);
            end
        end
        prev_pic = picture_active;
        prev_h   = h_addr;
        for (int i = 0; i < FT; i++) begin
            advance();
            exp = sb_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL pic_sb edge=%0d actual=%h required=%h", edges, obs, exp);
            end
            if (picture_active) begin
                pic_cnt++;
                last_row = int'(v_addr);
                if (rise_h < 0) begin
                    rise_h = int'(h_addr);
                    rise_v = int'(v_addr);
                end
            end
            if (prev_pic && !picture_active) begin
                falls++;
                if (prev_h != 10'(PX + PW - 1)) bad_falls++;
            end
            prev_pic = picture_active;
            prev_h   = h_addr;
        end
        vectors++;
        if (pic_cnt != PW * (VA - PY)) begin
            miscompares++;
            $display("FAIL pic_count actual=%0d required=%0d", pic_cnt, PW * (VA - PY));
        end
        vectors++;
        if (rise_h != PX || rise_v != PY) begin
            miscompares++;
            $display("FAIL pic_first_rise actual=(%0d,%0d) required=(%0d,%0d)",
                     rise_h, rise_v, PX, PY);
        end
        vectors++;
        if (falls != VA - PY || bad_falls != 0) begin
            miscompares++;
            $display("FAIL pic_falls actual n=%0d bad=%0d required n=%0d bad=0",
                     falls, bad_falls, VA - PY);
        end
        vectors++;
        if (last_row != VA - 1) begin
            miscompares++;
            $display("FAIL pic_last_row actual=%0d required=%0d", last_row, VA - 1);
        end
    endtask

    task automatic test_reset_mid_frame();
        vec_t exp;
        int early_hs;
        early_hs = 0;
        // Counter at v=4, h=5 after this edge.
        while ((edges % FT) != 4 * HT + 5) begin
            advance();
            exp = sb_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL midrst_sb edge=%0d actual=%h required=%h", edges, obs, exp);
            end
        end
        #5 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== RESET_VEC) begin
            miscompares++;
            $display("FAIL midrst_immediate actual=%h required=%h", obs, RESET_VEC);
        end
        edges = 0;
        repeat (3) begin
            @(posedge vga_clk);
            #1;
            vectors++;
            if (obs !== RESET_VEC) begin
                miscompares++;
                $display("FAIL midrst_hold actual=%h required=%h", obs, RESET_VEC);
            end
        end
        @(negedge vga_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * HT; i++) begin
            advance();
            exp = sb_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL midrst_sb edge=%0d actual=%h required=%h", edges, obs, exp);
            end
            if (i == 0) begin
                vectors++;
                if (h_addr !== 10'd0 || v_addr !== 10'd0 || frame_start !== 1'b1) begin
                    miscompares++;
                    $display("FAIL midrst_restart actual h=%0d v=%0d fs=%b required 0 0 1",
                             h_addr, v_addr, frame_start);
                end
            end
            if (i < HA + HF && !hsync) early_hs++;
        end
        vectors++;
        if (early_hs != 0) begin
            miscompares++;
            $display("FAIL midrst_hsync_glitch actual=%0d required=0", early_hs);
        end
    endtask

`ifdef VGA_FRAME_CNT_EN
    task automatic test_frame_cnt();
        vec_t exp;
        logic [7:0] fc_exp;
        int wraps, stop;
        logic [7:0] prev_fc;
        wraps = 0;
        stop = edges + 257 * FT;
        prev_fc = frame_cnt;
        while (edges < stop) begin
            advance();
            exp = sb_q.pop_front();
            fc_exp = 8'(((edges - 1) / FT + 1) % 256);
            vectors++;
            if (obs !== exp || frame_cnt !== fc_exp) begin
                miscompares++;
                $display("FAIL frame_cnt edge=%0d actual=%h/%0d required=%h/%0d",
                         edges, obs, frame_cnt, exp, fc_exp);
            end
            if (prev_fc == 8'd255 && frame_cnt == 8'd0) wraps++;
            prev_fc = frame_cnt;
        end
        vectors++;
        if (wraps != 1) begin
            miscompares++;
            $display("FAIL frame_cnt_wrap actual=%0d required=1", wraps);
        end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_picture();
        test_reset_mid_frame();
`ifdef VGA_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
